// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided fabric-clock generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_div_pkg;

  // Configuration handshake states
  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,  // waiting for a request
    C_PEND    = 2'd1,  // request latched, waiting for a safe boundary
    C_WAITLOW = 2'd2   // applied and acked, waiting for cfg_req to drop
  } cfg_state_t;

  localparam int DIV_W_DEF   = 4;  // half-period counter width
  localparam int DIV_RST_DEF = 3;  // half period of 4 CLK cycles, i.e. CLK/8

endpackage

// File: rtl/clk_div_core.sv
// Counter/toggle engine: fclk toggles every div_cur+1 CLK cycles, parks low on demand.
// Latency: fclk and its rise/fall strobes change on the same edge, one register stage.
// Backpressure: none; park holds cnt and fclk at 0 with no strobes.
//
// Ports:
//   CLK, reset_n      clock and asynchronous active-low reset
//   park              hold fclk low and the counter at 0
//   div_cur           current half-period count minus 1
//   fclk              divided clock (registered)
//   fclk_rise/_fall   one-cycle strobes in the cycle fclk becomes 1 / 0
//   bound_f           this edge makes fclk fall (safe point for ratio/stop changes)
module clk_div_core #(
  parameter int DIV_W = 4
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             park,
  input  logic [DIV_W-1:0] div_cur,
  output logic             fclk,
  output logic             fclk_rise,
  output logic             fclk_fall,
  output logic             bound_f
);

  logic [DIV_W-1:0] cnt;
  logic             tc;

  // Terminal count only matters while running; a parked core never toggles.
  assign tc      = !park && (cnt == div_cur);
  assign bound_f = tc && fclk;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      fclk      <= 1'b0;
      fclk_rise <= 1'b0;
      fclk_fall <= 1'b0;
    end else if (park) begin
      cnt       <= '0;
      fclk      <= 1'b0;
      fclk_rise <= 1'b0;
      fclk_fall <= 1'b0;
    end else if (tc) begin
      cnt       <= '0;
      fclk      <= ~fclk;
      fclk_rise <= ~fclk;
      fclk_fall <= fclk;
    end else begin
      cnt       <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
      fclk_rise <= 1'b0;
      fclk_fall <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable, stoppable fabric-clock generator with req/ack ratio reconfiguration.
// Latency: a new ratio or a stop lands at the next fclk falling edge (<= 2*(div_cur+1) cycles).
// Backpressure: cfg_req is held until the cfg_ack pulse; busy flags a pending request.
//
// Ports:
//   CLK, reset_n          clock and asynchronous active-low reset
//   cfg_req, cfg_div      level request and new half-period count minus 1
//   cfg_ack               one-cycle pulse when the new ratio takes effect
//   stop_req              level: 1 parks fclk low, 0 lets it run
//   fclk, fclk_rise/_fall divided clock and its edge strobes
//   stopped, busy         fclk parked / config request pending
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  input  logic             stop_req,
  output logic             fclk,
  output logic             fclk_rise,
  output logic             fclk_fall,
  output logic             stopped,
  output logic             busy
);

  cfg_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] div_nxt;
  logic             bound_f;
  logic             latch_div;
  logic             apply;

  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .park      (stopped),
    .div_cur   (div_cur),
    .fclk      (fclk),
    .fclk_rise (fclk_rise),
    .fclk_fall (fclk_fall),
    .bound_f   (bound_f)
  );

  // A ratio may only change where the counter restarts anyway: at the falling
  // edge (cnt==div_cur, so cnt<=0 follows) or while parked (cnt held at 0).
  // That keeps cnt<=div_cur and avoids any runt high phase.
  always_comb begin
    state_d   = state_q;
    latch_div = 1'b0;
    apply     = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (cfg_req) begin
          latch_div = 1'b1;
          state_d   = C_PEND;
        end
      end
      C_PEND: begin
        if (bound_f || stopped) begin
          apply   = 1'b1;
          state_d = C_WAITLOW;
        end
      end
      C_WAITLOW: begin
        // Requester must drop cfg_req before a new request is accepted
        if (!cfg_req) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= C_IDLE;
      div_nxt <= DIV_W'(DIV_RST);
      div_cur <= DIV_W'(DIV_RST);
      cfg_ack <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_ack <= apply;
      if (latch_div) begin
        div_nxt <= cfg_div;
      end
      if (apply) begin
        div_cur <= div_nxt;
      end
    end
  end

  // Stop is only honoured at the falling edge so the final high phase is full
  // length; dropping stop_req earlier simply cancels it. Release is immediate.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      stopped <= 1'b0;
    end else if (stopped) begin
      stopped <= stop_req;
    end else if (bound_f && stop_req) begin
      stopped <= 1'b1;
    end
  end

  assign busy = (state_q == C_PEND);

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       CLK;
  logic       reset_n;
  logic       cfg_req;
  logic [3:0] cfg_div;
  logic       cfg_ack;
  logic       stop_req;
  logic       fclk;
  logic       fclk_rise;
  logic       fclk_fall;
  logic       stopped;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  clk_div_ctrl #(.DIV_W(4), .DIV_RST(3)) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .cfg_req   (cfg_req),
    .cfg_div   (cfg_div),
    .cfg_ack   (cfg_ack),
    .stop_req  (stop_req),
    .fclk      (fclk),
    .fclk_rise (fclk_rise),
    .fclk_fall (fclk_fall),
    .stopped   (stopped),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Starting from cnt=0, fclk=0 (just after a fall, a release or reset),
  // check n edges of free running with half period h.
  task automatic check_run(input string tag, input int h, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk({tag, "_fclk"},    fclk,      ((i / h) % 2) == 1);
      chk({tag, "_rise"},    fclk_rise, (i % (2 * h)) == h);
      chk({tag, "_fall"},    fclk_fall, (i % (2 * h)) == 0);
      chk({tag, "_ack"},     cfg_ack,   1'b0);
      chk({tag, "_stopped"}, stopped,   1'b0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    cfg_req  = 1'b0;
    cfg_div  = 4'd0;
    stop_req = 1'b0;

    // Reset state
    #2;
    chk("rst_fclk",    fclk,      1'b0);
    chk("rst_rise",    fclk_rise, 1'b0);
    chk("rst_fall",    fclk_fall, 1'b0);
    chk("rst_ack",     cfg_ack,   1'b0);
    chk("rst_stopped", stopped,   1'b0);
    chk("rst_busy",    busy,      1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_hold_fclk", fclk, 1'b0);
    #3 reset_n = 1'b1;

    // 1: default divide-by-8, first rise on 4th edge
    check_run("t1", 4, 16);

    // 2: request cfg_div=1 during the high phase
    repeat (5) tick();
    chk("t2_high", fclk, 1'b1);
    cfg_req = 1'b1;
    cfg_div = 4'd1;
    tick();
    chk("t2_busy0", busy, 1'b1);
    chk("t2_ack0",  cfg_ack, 1'b0);
    tick();
    chk("t2_busy1", busy, 1'b1);
    chk("t2_fhigh", fclk, 1'b1);
    tick();
    chk("t2_ack",   cfg_ack,   1'b1);
    chk("t2_fall",  fclk_fall, 1'b1);
    chk("t2_flow",  fclk,      1'b0);
    chk("t2_busy2", busy,      1'b0);
    cfg_req = 1'b0;
    check_run("t2", 2, 8);

    // 3: cfg_div=0 (CLK/2), then cfg_div=5 (period 12)
    cfg_req = 1'b1;
    cfg_div = 4'd0;
    tick();
    chk("t3_busy", busy, 1'b1);
    repeat (3) tick();
    chk("t3_ack",  cfg_ack,   1'b1);
    chk("t3_fall", fclk_fall, 1'b1);
    cfg_req = 1'b0;
    check_run("t3a", 1, 6);
    cfg_req = 1'b1;
    cfg_div = 4'd5;
    tick();
    chk("t3b_rise", fclk_rise, 1'b1);
    tick();
    chk("t3b_ack",  cfg_ack,   1'b1);
    chk("t3b_fall", fclk_fall, 1'b1);
    cfg_req = 1'b0;
    check_run("t3b", 6, 24);

    // 4: stop raised during low phase; full high phase precedes the park
    repeat (2) tick();
    stop_req = 1'b1;
    for (int i = 3; i <= 12; i++) begin
      tick();
      chk("t4_fclk",    fclk,      (i >= 6) && (i < 12));
      chk("t4_rise",    fclk_rise, i == 6);
      chk("t4_fall",    fclk_fall, i == 12);
      chk("t4_stopped", stopped,   i == 12);
    end
    repeat (3) begin
      tick();
      chk("t4_park_fclk", fclk,      1'b0);
      chk("t4_park_stp",  stopped,   1'b1);
      chk("t4_park_rise", fclk_rise, 1'b0);
    end
    stop_req = 1'b0;
    tick();
    chk("t4_release", stopped, 1'b0);
    chk("t4_rel_fclk", fclk,   1'b0);
    check_run("t4r", 6, 12);

    // 4b: stop dropped before the falling edge is cancelled
    stop_req = 1'b1;
    repeat (3) tick();
    stop_req = 1'b0;
    repeat (9) tick();
    chk("t4c_fall",    fclk_fall, 1'b1);
    chk("t4c_stopped", stopped,   1'b0);
    repeat (6) tick();
    chk("t4c_rise",    fclk_rise, 1'b1);
    chk("t4c_stp2",    stopped,   1'b0);

    // 5: config while stopped, and no re-accept while cfg_req stays high
    stop_req = 1'b1;
    repeat (6) tick();
    chk("t5_stopped", stopped,   1'b1);
    chk("t5_fall",    fclk_fall, 1'b1);
    tick();
    cfg_req = 1'b1;
    cfg_div = 4'd2;
    tick();
    chk("t5_busy", busy,    1'b1);
    chk("t5_ack0", cfg_ack, 1'b0);
    tick();
    chk("t5_ack",   cfg_ack,   1'b1);
    chk("t5_fclk",  fclk,      1'b0);
    chk("t5_nofal", fclk_fall, 1'b0);
    chk("t5_busy2", busy,      1'b0);
    repeat (3) begin
      tick();
      chk("t5_hold_ack",  cfg_ack, 1'b0);
      chk("t5_hold_busy", busy,    1'b0);
    end
    cfg_req = 1'b0;
    tick();
    chk("t5_idle_busy", busy, 1'b0);
    cfg_req = 1'b1;
    tick();
    chk("t5_re_busy", busy, 1'b1);
    tick();
    chk("t5_re_ack", cfg_ack, 1'b1);
    cfg_req  = 1'b0;
    stop_req = 1'b0;
    tick();
    chk("t5_release", stopped, 1'b0);
    check_run("t5r", 3, 12);

    // 6: reset during a pending request
    cfg_req = 1'b1;
    cfg_div = 4'd7;
    tick();
    chk("t6_busy0", busy, 1'b1);
    repeat (2) tick();
    chk("t6_busy1", busy, 1'b1);
    chk("t6_fhigh", fclk, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_fclk", fclk,    1'b0);
    chk("t6_rst_busy", busy,    1'b0);
    chk("t6_rst_ack",  cfg_ack, 1'b0);
    cfg_req = 1'b0;
    #3 reset_n = 1'b1;
    check_run("t6", 4, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable, stoppable divided-clock generator with a request/acknowledge configuration port. It produces the fabric clock fclk from CLK. The divide ratio changes and stop/restart happen only at the fclk falling boundary, so fclk never has a runt pulse. It sits at the top of the core clocking path. It is driven by the system controller and consumed by downstream logic as the clock plus rise/fall strobes.

Parameters:
DIV_W, 4, width of the half-period count register.
DIV_RST, 3, half-period count loaded at reset; half period = DIV_RST+1 CLK cycles, so the default divides by 8.

Ports:
CLK  input  1  system clock; all logic on its rising edge.
reset_n  input  1  asynchronous active-low reset.
cfg_req  input  1  request to load cfg_div; level, held until cfg_ack is seen.
cfg_div  input  DIV_W  new half-period count minus 1; stable while cfg_req is high.
cfg_ack  output  1  one-cycle pulse when the new ratio takes effect.
stop_req  input  1  level; high requests fclk parked low, low lets fclk run.
fclk  output  1  divided clock, registered.
fclk_rise  output  1  one-cycle strobe in the cycle fclk becomes 1.
fclk_fall  output  1  one-cycle strobe in the cycle fclk becomes 0.
stopped  output  1  high while fclk is parked.
busy  output  1  high while a config request is pending (state C_PEND).

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low, on reset_n.
- Reset values:
  - fclk=0, cnt=0, div_cur=DIV_RST.
  - cfg_ack=0, fclk_rise=0, fclk_fall=0, stopped=0, busy=0.
  - Config FSM = C_IDLE. The block runs from reset.
- Counter (while running):
  - If cnt==div_cur: cnt<=0 and fclk<=~fclk. Otherwise cnt<=cnt+1.
  - Half period = div_cur+1 cycles. Full period = 2*(div_cur+1).
  - div_cur=0 gives CLK/2.
- Strobes: fclk_rise and fclk_fall are registered and asserted on the same edge that fclk changes.
- Boundary F: the cycle with running && cnt==div_cur && fclk==1, i.e. the edge at which fclk falls.
- Config FSM:
  - C_IDLE: if cfg_req=1, latch cfg_div into div_nxt, go to C_PEND.
  - C_PEND: busy=1. On boundary F: div_cur<=div_nxt, cnt<=0, fclk<=0, fclk_fall=1, cfg_ack=1 for that cycle, go to C_WAITLOW.
  - C_PEND while stopped: apply on the next cycle with the same effects (fclk stays 0, no fall strobe), ack, go to C_WAITLOW.
  - C_WAITLOW: wait for cfg_req=0, then go to C_IDLE. A request still high after ack is never re-accepted.
- Stop control:
  - While running with stop_req=1: at boundary F, fclk falls as normal, then stopped<=1. cnt is held 0 and fclk held 0.
  - If fclk is low when stop_req rises, the low phase completes, fclk rises, and the stop takes effect at the next boundary F. Worst-case stop latency = 2*(div_cur+1) cycles.
  - In stopped with stop_req=0: stopped<=0 next edge, cnt starts from 0. The first rise occurs div_cur+1 cycles after stopped falls.
  - stop_req deasserted before boundary F: the stop is cancelled and fclk is unaffected.
- Simultaneous events:
  - Config apply and stop at the same boundary F: both take effect on that edge (div_cur updated, ack pulsed, stopped set).
  - cfg_req and boundary F in the same cycle while in C_IDLE: the request is only latched in that cycle and is applied at the next boundary F.
- Reset mid-operation: a pending request is dropped with no ack. fclk goes low immediately (asynchronous). The requester must re-issue the request.
- Widths: cnt and div_cur are DIV_W bits, compared unsigned. cnt never exceeds div_cur because it is reloaded at every apply.

Decomposition:
- Package clk_div_pkg holds:
  - the config FSM state enum {C_IDLE, C_PEND, C_WAITLOW};
  - default DIV_W and DIV_RST constants.
- One sub-module, clk_div_core: counter, fclk toggle, strobes, run/park. It exports the boundary-F indication.
- The parent holds the config FSM and stop logic.

Test Plan:
1. Reset release with defaults (DIV_W=4, DIV_RST=3) -> fclk rises on the 4th CLK edge. Period 8, 50% duty. fclk_rise and fclk_fall alternate every 4 edges.
2. cfg_req with cfg_div=1 asserted mid-high-phase -> busy=1 until boundary F. cfg_ack pulses with fclk_fall. Period then becomes 4; no high phase shorter than the old half-period.
3. cfg_div=0 -> after ack, fclk toggles every cycle (CLK/2). A following request with cfg_div=5 -> period 12 after its ack.
4. stop_req raised while fclk=0 -> the low phase completes, a full high phase follows, then fclk falls and stopped=1. Release -> stopped=0 and the first rise div_cur+1 cycles later.
5. cfg_req while stopped -> cfg_ack next cycle, fclk stays 0. On release, the new ratio is used. Holding cfg_req high after ack -> no second ack until it toggles low and back high.
6. reset_n pulsed low during C_PEND -> fclk=0 immediately, no cfg_ack, div_cur=3 after reset.
